// File: rtl/cart_loader.sv
// cart_loader: buffers HPS ioctl download bytes and replays them one at a
// time onto the cartridge SDRAM write port (mem_we / mem_ack handshake).
// It also derives cartridge metadata (cart_pages, sg1000, extram) while the
// bytes are being accepted.
// Build option: define CART_LOADER_CHECKSUM_EN to add a 16-bit byte-sum
// output (checksum) covering every byte accepted into the FIFO.

module cart_loader #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [4:0] INDEX_SG   = 5'd2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        loading,
   output logic        load_done,
   output logic        overflow,
   output logic [5:0]  cart_pages,
   output logic        sg1000,
   output logic        extram
`ifdef CART_LOADER_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WAIT
   } state_t;

   state_t        state, state_next;
   logic [32:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic          fifo_empty, fifo_full;
   logic          pop, push_ok, drop;
   logic          dl_prev, dl_rise, load_end;
   logic          ff_flag, seen_top, in_ff_window;

   // Upper index bits carry no meaning for this core.
   logic          unused_index;
   assign unused_index = &{1'b0, ioctl_index[7:5]};

   assign fifo_empty   = (count == '0);
   assign fifo_full    = (count == DEPTH_C);
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push_ok      = ioctl_wr & (~fifo_full | pop);
   assign drop         = ioctl_wr & ~push_ok;
   assign dl_rise      = ioctl_download & ~dl_prev;
   assign load_end     = loading & ~ioctl_download & fifo_empty & (state == ST_IDLE);
   assign in_ff_window = (ioctl_addr[24:13] == 12'd1);
   assign extram       = sg1000 & ff_flag & seen_top;

   // Write-FSM state register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Write-FSM next state, pop request and the one-cycle mem_we strobe.
   // NOTE: every output gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      mem_we     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_we     = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_ack) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_next = count;
      case ({push_ok, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // FIFO storage: written on accepted pushes only.
   // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk_sys) begin
      if (push_ok) fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
   end

   // FIFO pointers and occupancy; reset discards any queued bytes.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
      end
   end

   // Head-of-FIFO write register; held stable through WRITE and WAIT.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mem_addr <= '0;
         mem_din  <= '0;
      end else if (pop) begin
         {mem_addr, mem_din} <= fifo_mem[rd_ptr];
      end
   end

   // Download tracking: loading window, completion pulse, stall and drop flags.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dl_prev    <= 1'b0;
         loading    <= 1'b0;
         load_done  <= 1'b0;
         overflow   <= 1'b0;
         ioctl_wait <= 1'b0;
      end else begin
         dl_prev    <= ioctl_download;
         load_done  <= load_end;
         ioctl_wait <= (count_next >= WAIT_LVL);
         if (dl_rise)       loading <= 1'b1;
         else if (load_end) loading <= 1'b0;
         if (drop)          overflow <= 1'b1;
         else if (dl_rise)  overflow <= 1'b0;
      end
   end

   // Cartridge metadata, updated as bytes are accepted; address 0 starts a new image.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sg1000     <= 1'b0;
         cart_pages <= '0;
         ff_flag    <= 1'b0;
         seen_top   <= 1'b0;
      end else if (push_ok) begin
         if (ioctl_addr == 25'd0) begin
            sg1000     <= (ioctl_index[4:0] == INDEX_SG);
            cart_pages <= '0;
            ff_flag    <= 1'b1;
            seen_top   <= 1'b0;
         end else begin
            if (ioctl_addr[19:14] > cart_pages) cart_pages <= ioctl_addr[19:14];
            if (in_ff_window) ff_flag <= ff_flag & (ioctl_dout == 8'hFF);
            if (ioctl_addr == 25'h3FFF) seen_top <= 1'b1;
         end
      end
   end

`ifdef CART_LOADER_CHECKSUM_EN
   // Running byte sum of the current image, restarted by the byte at address 0.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         checksum <= '0;
      end else if (push_ok) begin
         if (ioctl_addr == 25'd0) checksum <= {8'h00, ioctl_dout};
         else                     checksum <= checksum + {8'h00, ioctl_dout};
      end
   end
`else
   // Default build: accepted bytes are not summed.
`endif

endmodule

// File: tb/tb_cart_loader.sv
// Directed testbench for cart_loader: Coleco and SG-1000 images, burst
// overflow, metadata boundaries and reset in the middle of a write.
// Define CART_LOADER_CHECKSUM_EN for both files to also cover the checksum.

module tb_cart_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic        mem_ack;
   logic        loading;
   logic        load_done;
   logic        overflow;
   logic [5:0]  cart_pages;
   logic        sg1000;
   logic        extram;
`ifdef CART_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int          n_checks  = 0;
   int          n_pass    = 0;
   int          ack_delay = 1;
   int          wait_seen = 0;
   int          done_seen = 0;
   logic [32:0] we_log[$];

   always #5 clk_sys = ~clk_sys;

   cart_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_we         (mem_we),
      .mem_ack        (mem_ack),
      .loading        (loading),
      .load_done      (load_done),
      .overflow       (overflow),
      .cart_pages     (cart_pages),
      .sg1000         (sg1000),
      .extram         (extram)
`ifdef CART_LOADER_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] t1_byte(input int i);
      return 8'((i * 13 + 7) % 256);
   endfunction

   // Record every write strobe and count stall / completion cycles.
   always @(negedge clk_sys) begin
      if (mem_we)     we_log.push_back({mem_addr, mem_din});
      if (ioctl_wait) wait_seen++;
      if (load_done)  done_seen++;
   end

   // SDRAM model: ack pulse ack_delay cycles after each mem_we.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (mem_we) begin
            repeat (ack_delay) @(negedge clk_sys);
            mem_ack = 1'b1;
            @(negedge clk_sys);
            mem_ack = 1'b0;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   // One byte strobe, then three idle cycles.
   task automatic put(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic start_load(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic finish_load(input string tag);
      int k;
      ioctl_download = 1'b0;
      k = 0;
      while (loading && k < 400) begin
         @(negedge clk_sys);
         k++;
      end
      check({tag, " drained"}, 32'(loading), 32'd0);
      repeat (2) @(negedge clk_sys);
   endtask

   initial begin
      int          lat;
      int          n_we;
      logic [5:0]  exp_wait;

      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'h00;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      repeat (3) @(negedge clk_sys);

      // Reset state
      check("rst flags", 32'({ioctl_wait, mem_we, loading, load_done, overflow, sg1000, extram}), 32'd0);
      check("rst cart_pages", 32'(cart_pages), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'd0);
      check("rst mem_din", 32'(mem_din), 32'd0);
`ifdef CART_LOADER_CHECKSUM_EN
      check("rst checksum", 32'(checksum), 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk_sys);

      // 16-byte Coleco image, one byte every 4 cycles, ack one cycle after mem_we
      ack_delay = 1;
      we_log.delete();
      wait_seen = 0;
      done_seen = 0;
      start_load(8'h00);
      check("t1 loading set", 32'(loading), 32'd1);
      for (int i = 0; i < 15; i++) put(25'(i), t1_byte(i));
      ioctl_addr = 25'd15;
      ioctl_dout = t1_byte(15);
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_sys);
         if (load_done && lat == 0) lat = k;
      end
      // Last byte: pop, WRITE, WAIT(ack), IDLE, then load_done -> 3 cycles after download falls.
      check("t1 load_done latency", 32'(lat), 32'd3);
      check("t1 load_done pulses", 32'(done_seen), 32'd1);
      check("t1 mem_we count", 32'(we_log.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t1 addr[%0d]", i), 32'(we_log[i][32:8]), 32'(i));
         check($sformatf("t1 data[%0d]", i), 32'(we_log[i][7:0]), 32'(t1_byte(i)));
      end
      check("t1 ioctl_wait never", 32'(wait_seen), 32'd0);
      check("t1 loading cleared", 32'(loading), 32'd0);
      check("t1 cart_pages", 32'(cart_pages), 32'd0);
      check("t1 sg1000", 32'(sg1000), 32'd0);

      // Burst every cycle, ack 10 cycles late: stall at 3 held, drop when full
      ack_delay = 10;
      we_log.delete();
      start_load(8'h00);
      exp_wait = 6'b110000;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t2 ioctl_wait@%0d", k), 32'(ioctl_wait), 32'(exp_wait[k]));
         check($sformatf("t2 overflow@%0d", k), 32'(overflow), 32'd0);
         ioctl_addr = 25'(k);
         ioctl_dout = 8'(8'hC0 + k);
         ioctl_wr   = 1'b1;
         @(negedge clk_sys);
      end
      ioctl_wr = 1'b0;
      check("t2 overflow after drop", 32'(overflow), 32'd1);
      check("t2 ioctl_wait full", 32'(ioctl_wait), 32'd1);
      finish_load("t2");
      check("t2 writes issued", 32'(we_log.size()), 32'd5);
      check("t2 last write", 32'(we_log[4]), 32'({25'd4, 8'hC4}));
      check("t2 overflow sticky", 32'(overflow), 32'd1);
      start_load(8'h00);
      check("t2 overflow cleared", 32'(overflow), 32'd0);
      finish_load("t2b");

      // Coleco image reaching 0x47FFF; FF data in the window must not set extram
      ack_delay = 1;
      start_load(8'h00);
      put(25'h00000, 8'h12);
      put(25'h02000, 8'hFF);
      put(25'h03FFF, 8'hFF);
      put(25'h24000, 8'h34);
      check("t3 cart_pages mid", 32'(cart_pages), 32'h09);
      put(25'h47FFF, 8'h56);
      put(25'h04000, 8'h78);
      finish_load("t3");
      check("t3 cart_pages", 32'(cart_pages), 32'h11);
      check("t3 sg1000", 32'(sg1000), 32'd0);
      check("t3 extram non-SG", 32'(extram), 32'd0);

      // SG image with 0x2000-0x3FFF all 0xFF
      start_load(8'h02);
      put(25'h0000, 8'hF3);
      put(25'h1FFF, 8'h00);
      put(25'h2000, 8'hFF);
      put(25'h2A55, 8'hFF);
      put(25'h3000, 8'hFF);
      check("t4 extram before top", 32'(extram), 32'd0);
      put(25'h3FFF, 8'hFF);
      finish_load("t4");
      check("t4 sg1000", 32'(sg1000), 32'd1);
      check("t4 extram", 32'(extram), 32'd1);
      check("t4 cart_pages", 32'(cart_pages), 32'd0);

      // Same SG image with 0xFE at 0x3000 (index upper bits set)
      start_load(8'hE2);
      put(25'h0000, 8'hF3);
      put(25'h2000, 8'hFF);
      put(25'h3000, 8'hFE);
      put(25'h3FFF, 8'hFF);
      finish_load("t5");
      check("t5 sg1000", 32'(sg1000), 32'd1);
      check("t5 extram", 32'(extram), 32'd0);

      // SG image truncated at 0x3000
      start_load(8'h02);
      put(25'h0000, 8'hF3);
      put(25'h2000, 8'hFF);
      put(25'h2FFF, 8'hFF);
      finish_load("t6");
      check("t6 sg1000", 32'(sg1000), 32'd1);
      check("t6 extram", 32'(extram), 32'd0);

      // Reset while in WAIT with 2 bytes queued
      ack_delay = 10;
      we_log.delete();
      start_load(8'h02);
      ioctl_addr = 25'h0000; ioctl_dout = 8'h01; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_addr = 25'h8000; ioctl_dout = 8'hFF;
      @(negedge clk_sys);
      ioctl_addr = 25'h8001; ioctl_dout = 8'h80;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check("t7 pre sg1000", 32'(sg1000), 32'd1);
      check("t7 pre cart_pages", 32'(cart_pages), 32'd2);
      check("t7 pre mem_din", 32'(mem_din), 32'h01);
      check("t7 pre writes", 32'(we_log.size()), 32'd1);
`ifdef CART_LOADER_CHECKSUM_EN
      check("t7 checksum", 32'(checksum), 32'h0180);
`endif
      reset          = 1'b1;
      ioctl_download = 1'b0;
      #1;
      check("t7 rst loading", 32'(loading), 32'd0);
      check("t7 rst metadata", 32'({cart_pages, sg1000, extram}), 32'd0);
      check("t7 rst mem_din", 32'(mem_din), 32'd0);
      @(negedge clk_sys);
      check("t7 rst mem_we", 32'(mem_we), 32'd0);
      reset = 1'b0;
      n_we  = we_log.size();
      repeat (30) @(negedge clk_sys);
      check("t7 no writes after reset", 32'(we_log.size()), 32'(n_we));
      check("t7 loading idle", 32'(loading), 32'd0);
      check("t7 ioctl_wait idle", 32'(ioctl_wait), 32'd0);
`ifdef CART_LOADER_CHECKSUM_EN
      check("t7 checksum reset", 32'(checksum), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
